dbus_bridge: RTL

- Sits directly downstream of the core's memory stage.
- Converts the core's data-bus request/response pair into a single-outstanding transaction on the memory-side handshake bus.
- Holds the core request stable toward memory and returns exactly one read or write completion per accepted request.
- The core's memory stage stalls on the pipeline until the completion (data_ok) is seen.

---
 rtl/dbus_bridge_if.sv | 55 +++++
 rtl/dbus_bridge.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dbus_bridge_if.sv
// ---------------------------------------------------------------------------
// dbus_bridge_if
// Signal bundle shared by the core data bus and the memory-side handshake
// bus that dbus_bridge converts between.
//
// Signals:
//   dreq_*   core request   (valid, addr, size, strobe, data)
//   dresp_*  core response  (addr_ok, data_ok, data, err)
//   mreq_*   memory request (valid, write, addr, size, strobe, wdata)
//   mresp_*  memory response(ready, valid, rdata)
//
// Modports:
//   slave  - the bridge itself: consumes dreq_*/mresp_*, drives dresp_*/mreq_*
//   master - the environment (core + memory): the mirror image
// ---------------------------------------------------------------------------
interface dbus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [3:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_data;

    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;
    logic              dresp_err;

    logic              mreq_valid;
    logic              mreq_write;
    logic [ADDR_W-1:0] mreq_addr;
    logic [2:0]        mreq_size;
    logic [3:0]        mreq_strobe;
    logic [DATA_W-1:0] mreq_wdata;

    logic              mresp_ready;
    logic              mresp_valid;
    logic [DATA_W-1:0] mresp_rdata;

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err,
        output mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_wdata,
        input  mresp_ready, mresp_valid, mresp_rdata
    );

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err,
        input  mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_strobe, mreq_wdata,
        output mresp_ready, mresp_valid, mresp_rdata
    );
endinterface

// File: rtl/dbus_bridge.sv
// ---------------------------------------------------------------------------
// dbus_bridge
// Converts the core's data-bus request/response pair into a single
// outstanding transaction on the memory handshake bus. One request is
// accepted (addr_ok pulse), latched, issued to memory, and exactly one
// completion (data_ok pulse) is returned to the core.
//
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high reset; abandons any transaction
//   bus    - dbus_bridge_if.slave: dreq_*/dresp_* toward the core,
//            mreq_*/mresp_* toward memory
//
// Parameters:
//   TIMEOUT - cycles allowed in WAIT before an error completion (0 = off)
//   ADDR_W  - address width
//   DATA_W  - data width (only 32 is supported)
//
// Build option:
//   DBUS_ALIGN_CHECK_EN - when defined, misaligned half/word requests are
//                         completed immediately with err=1 and never
//                         reach memory.
// ---------------------------------------------------------------------------
module dbus_bridge #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input logic         clk,
    input logic         reset,
    dbus_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    // Counter only ever needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [3:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              misaligned;

`ifdef DBUS_ALIGN_CHECK_EN
    assign misaligned = ((bus.dreq_size == 3'd1) && bus.dreq_addr[0]) ||
                        ((bus.dreq_size == 3'd2) && (bus.dreq_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // NOTE: every signal gets its default before the case so no path
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.dreq_valid) begin
                    addr_d   = bus.dreq_addr;
                    size_d   = bus.dreq_size;
                    strobe_d = bus.dreq_strobe;
                    wdata_d  = bus.dreq_data;
                    write_d  = |bus.dreq_strobe;
                    if (misaligned) begin
                        // Rejected without touching memory.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.mresp_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the same cycle as the timeout takes priority.
                if (bus.mresp_valid) begin
                    rdata_d = write_q ? '0 : bus.mresp_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    // NOTE: the request latches are reset too, so mreq_* and dresp_* read
    // 0 after reset rather than stale or unknown values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // addr_ok is combinational from dreq_valid; masked during reset so all
    // outputs read 0 while reset is held even if the core keeps requesting.
    assign bus.dresp_addr_ok = (state_q == S_IDLE) && bus.dreq_valid && !reset;
    assign bus.dresp_data_ok = (state_q == S_DONE);
    assign bus.dresp_data    = rdata_q;
    assign bus.dresp_err     = err_q;

    assign bus.mreq_valid    = (state_q == S_ISSUE);
    assign bus.mreq_write    = write_q;
    assign bus.mreq_addr     = addr_q;
    assign bus.mreq_size     = size_q;
    assign bus.mreq_strobe   = strobe_q;
    assign bus.mreq_wdata    = wdata_q;

endmodule
